// File: rtl/clock_divider_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_divider_bank: NUM_CH programmable square-wave dividers with ticks  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clock_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 32,
  parameter int DEBUG_STEP  = 120,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic              input_clock,
  input  logic              reset_n,
  input  logic              debug,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync_restart,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] output_clock,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  localparam logic [CNT_W:0]   STEP_DBG = (CNT_W+1)'(DEBUG_STEP);
  localparam logic [CNT_W:0]   STEP_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [CNT_W:0] step;
  logic           cfg_ok;
  logic           cfg_err_d, cfg_err_q;

  always_comb begin
    step      = debug ? STEP_DBG : STEP_ONE;
    cfg_ok    = ({1'b0, cfg_ch} < NUM_CH_L) && (cfg_div >= CNT_W'(2)) &&
                (cfg_high != '0) && (cfg_high < cfg_div);
    cfg_err_d = cfg_wr && !cfg_ok;
  end

  always_ff @(posedge input_clock or negedge reset_n) begin
    if (!reset_n) cfg_err_q <= 1'b0;
    else          cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] count_d, count_q;
    logic [CNT_W-1:0] div_d, div_q;
    logic [CNT_W-1:0] high_d, high_q;
    logic             oclk_d, oclk_q;
    logic             tick_d, tick_q;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   rem;
    logic             wr_hit;

    always_comb begin
      sum     = {1'b0, count_q} + step;
      rem     = sum - {1'b0, div_q};
      wr_hit  = cfg_wr && cfg_ok && (cfg_ch == CH_W'(i));
      count_d = count_q;
      div_d   = div_q;
      high_d  = high_q;
      tick_d  = 1'b0;
      // Restart clears counts but still lets a coincident valid write land.
      if (wr_hit) begin
        div_d  = cfg_div;
        high_d = cfg_high;
      end
      if (sync_restart || wr_hit) begin
        count_d = '0;
      end else if (enable[i]) begin
        if (sum < {1'b0, div_q}) begin
          count_d = sum[CNT_W-1:0];
        end else begin
          // Keep the remainder so the average rate stays exact under debug stepping.
          count_d = (rem < {1'b0, div_q}) ? rem[CNT_W-1:0] : '0;
          tick_d  = 1'b1;
        end
      end
      oclk_d = (count_d >= high_d);
    end

    always_ff @(posedge input_clock or negedge reset_n) begin
      if (!reset_n) begin
        count_q <= '0;
        div_q   <= RST_DIV;
        high_q  <= RST_HIGH;
        oclk_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        count_q <= count_d;
        div_q   <= div_d;
        high_q  <= high_d;
        oclk_q  <= oclk_d;
        tick_q  <= tick_d;
      end
    end

    assign output_clock[i] = oclk_q;
    assign tick[i]         = tick_q;
  end

endmodule
`default_nettype wire
